// File: rtl/irom_arb_pkg.sv
// irom_arb_pkg: shared definitions for the instruction-ROM arbiter.
//   state_e        : arbiter FSM encoding (ST_IDLE=1'b0, ST_BUSY=1'b1)
//   IROM_ARB_MAX_N : largest supported requester count
//   ptr_width()    : width of the round-robin pointer for a given N
package irom_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam int IROM_ARB_MAX_N = 8;

  // A pointer needs at least one bit even when N would need zero.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/irom_arb_pick.sv
// irom_arb_pick: combinational one-hot picker.
// Returns the first set bit of i_req at or after index i_ptr, wrapping from
// N-1 back to 0. With i_ptr tied to 0 this is plain lowest-index priority.
// Ports:
//   i_req   [N-1:0]  request vector
//   i_ptr   [PW-1:0] starting index for the search (must be < N)
//   o_grant [N-1:0]  one-hot winner, zero when i_req is zero
module irom_arb_pick
  import irom_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant
);

  logic [2*N-1:0] w_req_dbl;
  logic [N-1:0]   w_rot;
  logic [N-1:0]   w_rot_pick;
  logic [2*N-1:0] w_pick_dbl;

  // Rotate right by the pointer so the search always starts at bit 0,
  // isolate the lowest set bit, then rotate the result back into place.
  assign w_req_dbl  = {i_req, i_req} >> i_ptr;
  assign w_rot      = w_req_dbl[N-1:0];
  assign w_rot_pick = w_rot & (~w_rot + N'(1));
  assign w_pick_dbl = {w_rot_pick, w_rot_pick} << i_ptr;
  assign o_grant    = w_pick_dbl[2*N-1:N];

endmodule

// File: rtl/irom_arb.sv
// irom_arb: Wishbone arbiter sharing one registered-read instruction ROM
// between N read-only requesters. Exactly one ROM cycle is in flight at a
// time; the ROM ack is routed to the granted requester only, read data is
// broadcast.
//
// Handshake: a requester holds req_cyc and a stable req_addr until it sees
// its req_ack bit; that single ack cycle carries valid req_rdata. Dropping
// req_cyc before the ack abandons the access: the ROM cycle still completes
// but no ack is delivered.
//
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   req_addr    N*AW  requester word addresses, requester i at [i*AW +: AW]
//   req_cyc     N     cycle requests
//   req_ack     N     per-requester ack (one-hot or zero)
//   req_rdata   32    broadcast read data, valid with req_ack
//   rom_addr    AW    ROM address, held for the whole cycle, 0 when idle
//   rom_cyc     1     ROM cycle strobe (high while BUSY)
//   rom_rdata   32    ROM read data
//   rom_ack     1     ROM ack
//   grant       N     one-hot current owner, 0 when idle (FSM status)
//
// Build option: define IROM_ARB_RR_EN for round-robin arbitration; without
// it the lowest requesting index always wins.
module irom_arb
  import irom_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int AW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N*AW-1:0] req_addr,
  input  logic [N-1:0]    req_cyc,
  output logic [N-1:0]    req_ack,
  output logic [31:0]     req_rdata,
  output logic [AW-1:0]   rom_addr,
  output logic            rom_cyc,
  input  logic [31:0]     rom_rdata,
  input  logic            rom_ack,
  output logic [N-1:0]    grant
);

  localparam int PW = ptr_width(N);

  state_e        r_state;
  state_e        w_state_nxt;
  logic [N-1:0]  r_grant;
  logic [N-1:0]  w_grant_nxt;
  logic [AW-1:0] r_addr;
  logic [AW-1:0] w_addr_nxt;
  logic [N-1:0]  w_pick;
  logic [AW-1:0] w_sel_addr;
  logic [PW-1:0] w_ptr;

  irom_arb_pick #(
    .N  (N),
    .PW (PW)
  ) u_pick (
    .i_req   (req_cyc),
    .i_ptr   (w_ptr),
    .o_grant (w_pick)
  );

  // Address of the requester the picker would grant right now.
  always_comb begin
    w_sel_addr = '0;
    for (int i = 0; i < N; i++) begin
      if (w_pick[i]) begin
        w_sel_addr = w_sel_addr | req_addr[i*AW +: AW];
      end
    end
  end

`ifdef IROM_ARB_RR_EN
  // Pointer holds (last granted index + 1) mod N and moves on every grant.
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_ptr_nxt;
  logic          w_start;

  assign w_start = (r_state == ST_IDLE) && (|req_cyc);

  always_comb begin
    w_ptr_nxt = '0;
    for (int i = 0; i < N; i++) begin
      if (w_pick[i]) begin
        w_ptr_nxt = (i == N - 1) ? '0 : PW'(i + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_start) begin
      r_ptr <= w_ptr_nxt;
    end
  end

  assign w_ptr = r_ptr;
`else
  assign w_ptr = '0;
`endif

  // Next-state logic. Grant and address are captured on entry to BUSY so
  // rom_addr cannot move while the ROM cycle is open.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_addr_nxt  = r_addr;
    case (r_state)
      ST_IDLE: begin
        if (|req_cyc) begin
          w_state_nxt = ST_BUSY;
          w_grant_nxt = w_pick;
          w_addr_nxt  = w_sel_addr;
        end
      end
      ST_BUSY: begin
        // rom_ack is the only way out; an aborted requester still waits
        // for the ROM to finish so no second cycle overlaps it.
        if (rom_ack) begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = '0;
          w_addr_nxt  = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_addr  <= w_addr_nxt;
    end
  end

  assign rom_cyc   = (r_state == ST_BUSY);
  assign rom_addr  = r_addr;
  assign grant     = r_grant;
  // grant is zero in IDLE, so a stray ROM ack there reaches nobody.
  assign req_ack   = {N{rom_ack}} & r_grant & req_cyc;
  assign req_rdata = rom_rdata;

endmodule

// File: tb/tb_irom_arb.sv
// tb_irom_arb: directed bench for irom_arb (N=2, AW=8) with a behavioural
// 256x32 ROM preloaded with mem[i] = 0xA5000000 + i, registered read and a
// toggling one-cycle ack. Outputs are sampled 2 time units after each
// rising edge; inputs are driven at the same point.
// Honours IROM_ARB_RR_EN to select round-robin expectations.
module tb_irom_arb;

  localparam int N  = 2;
  localparam int AW = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    req_cyc;
  logic [N-1:0]    req_ack;
  logic [31:0]     req_rdata;
  logic [AW-1:0]   rom_addr;
  logic            rom_cyc;
  logic [31:0]     rom_rdata;
  logic            rom_ack = 1'b0;
  logic [N-1:0]    grant;

  logic [31:0]     mem [256];
  int              checks = 0;
  int              errors = 0;
  logic [31:0]     exp_q [$];

  // ---------------- clock / DUT / ROM ----------------
  always #5 clk = ~clk;

  irom_arb #(
    .N  (N),
    .AW (AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_addr  (req_addr),
    .req_cyc   (req_cyc),
    .req_ack   (req_ack),
    .req_rdata (req_rdata),
    .rom_addr  (rom_addr),
    .rom_cyc   (rom_cyc),
    .rom_rdata (rom_rdata),
    .rom_ack   (rom_ack),
    .grant     (grant)
  );

  always @(posedge clk) begin
    rom_ack   <= rom_cyc & ~rom_ack;
    rom_rdata <= mem[rom_addr];
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a);
    req_addr[i*AW +: AW] = a;
    req_cyc[i]           = 1'b1;
  endtask

  task automatic drop_req(input int i);
    req_cyc[i] = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard: pop the next expected read word when an ack is due.
  task automatic expect_ack(input string tag, input logic [N-1:0] exp_ack);
    logic [31:0] exp_d;
    check({tag, "_ack"}, 32'(req_ack), 32'(exp_ack));
    if (exp_q.size() == 0) begin
      check({tag, "_q_underflow"}, 32'(exp_q.size()), 32'd1);
    end else begin
      exp_d = exp_q.pop_front();
      check({tag, "_rdata"}, req_rdata, exp_d);
    end
  endtask

  // Reference arbitration: descending scan, last hit (lowest offset) wins.
  function automatic logic [N-1:0] model_pick(input logic [N-1:0] r, input int p);
    logic [N-1:0] g;
    int           idx;
    g = '0;
    for (int k = N - 1; k >= 0; k--) begin
`ifdef IROM_ARB_RR_EN
      idx = (p + k) % N;
`else
      idx = k + (p * 0);
`endif
      if (r[idx]) begin
        g      = '0;
        g[idx] = 1'b1;
      end
    end
    return g;
  endfunction

  // ---------------- stimulus ----------------
  logic [N-1:0] exp_win;
  int           c0, c1, diff;
  logic         m_busy;
  logic [N-1:0] m_grant;
  logic [AW-1:0] m_addr;
  int           m_ptr;
  logic [N-1:0] exp_ack;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 + 32'(i);
    rst_n    = 1'b0;
    req_cyc  = '0;
    req_addr = '0;
    step();
    step();
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_rom_cyc", 32'(rom_cyc), 32'd0);
    check("rst_req_ack", 32'(req_ack), 32'd0);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    rst_n = 1'b1;
    step();

    // Simultaneous requests: requester 0 first (pointer is 0 after reset).
    set_req(0, 8'h01);
    set_req(1, 8'h02);
    exp_q.push_back(32'hA500_0001);
    exp_q.push_back(32'hA500_0002);
    step();
    check("sim_grant0", 32'(grant), 32'b01);
    check("sim_rom_cyc", 32'(rom_cyc), 32'd1);
    check("sim_addr0", 32'(rom_addr), 32'h01);
    check("sim_early_ack", 32'(req_ack), 32'd0);
    step();
    expect_ack("sim0", 2'b01);
    drop_req(0);
    step();
    check("sim_idle_gap", 32'(grant), 32'd0);
    step();
    check("sim_grant1", 32'(grant), 32'b10);
    check("sim_addr1", 32'(rom_addr), 32'h02);
    step();
    expect_ack("sim1", 2'b10);
    drop_req(1);
    step();
    check("sim_end_idle", 32'(rom_cyc), 32'd0);

    // Single request, address 0x12.
    set_req(0, 8'h12);
    exp_q.push_back(32'hA500_0012);
    step();
    check("one_grant", 32'(grant), 32'b01);
    check("one_rom_cyc", 32'(rom_cyc), 32'd1);
    check("one_addr", 32'(rom_addr), 32'h12);
    check("one_no_ack", 32'(req_ack), 32'd0);
    step();
    expect_ack("one", 2'b01);
    drop_req(0);
    step();
    check("one_idle_grant", 32'(grant), 32'd0);
    check("one_idle_cyc", 32'(rom_cyc), 32'd0);
    check("one_idle_addr", 32'(rom_addr), 32'd0);

    // Continuous contention for 30 cycles; pointer is 1 in round-robin mode.
`ifdef IROM_ARB_RR_EN
    exp_win = 2'b10;
`else
    exp_win = 2'b01;
`endif
    c0 = 0;
    c1 = 0;
    set_req(0, 8'h40);
    set_req(1, 8'h41);
    for (int k = 1; k <= 30; k++) begin
      step();
      check("cont_onehot", 32'($countones(req_ack) <= 1), 32'd1);
      if (req_ack != '0) begin
        check("cont_winner", 32'(req_ack), 32'(exp_win));
        check("cont_rdata", req_rdata, exp_win[0] ? 32'hA500_0040 : 32'hA500_0041);
        if (req_ack[0]) c0++;
        if (req_ack[1]) c1++;
`ifdef IROM_ARB_RR_EN
        exp_win = ~exp_win;
`endif
      end
    end
    drop_req(0);
    drop_req(1);
    check("cont_total", 32'(c0 + c1), 32'd10);
`ifdef IROM_ARB_RR_EN
    diff = (c0 > c1) ? c0 - c1 : c1 - c0;
    check("cont_fair", 32'(diff <= 1), 32'd1);
`else
    check("cont_prio_c1", 32'(c1), 32'd0);
`endif
    step();
    check("cont_end_idle", 32'(grant), 32'd0);

    // Abort: requester 1 drops after its grant; pending requester 0 follows.
    set_req(1, 8'h07);
    step();
    check("abort_grant", 32'(grant), 32'b10);
    drop_req(1);
    set_req(0, 8'h03);
    exp_q.push_back(32'hA500_0003);
    step();
    check("abort_no_ack", 32'(req_ack), 32'd0);
    check("abort_rom_cyc", 32'(rom_cyc), 32'd1);
    step();
    check("abort_idle_grant", 32'(grant), 32'd0);
    check("abort_idle_cyc", 32'(rom_cyc), 32'd0);
    step();
    check("abort_next_grant", 32'(grant), 32'b01);
    check("abort_next_addr", 32'(rom_addr), 32'h03);
    step();
    expect_ack("abort_next", 2'b01);
    drop_req(0);
    step();

    // Reset during BUSY; the ROM's ack then arrives while idle.
    set_req(0, 8'h20);
    step();
    check("rb_grant", 32'(grant), 32'b01);
    rst_n = 1'b0;
    step();
    check("rb_grant_clr", 32'(grant), 32'd0);
    check("rb_rom_cyc", 32'(rom_cyc), 32'd0);
    check("rb_rom_addr", 32'(rom_addr), 32'd0);
    check("rb_stray_ack", 32'(req_ack), 32'd0);
    rst_n = 1'b1;
    exp_q.push_back(32'hA500_0020);
    step();
    check("rb_regrant", 32'(grant), 32'b01);
    check("rb_recyc", 32'(rom_cyc), 32'd1);
    step();
    expect_ack("rb", 2'b01);
    drop_req(0);
    step();

    // Random traffic against a cycle model; fresh reset so pointer is 0.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    m_busy  = 1'b0;
    m_grant = '0;
    m_addr  = '0;
    m_ptr   = 0;
    for (int c = 0; c < 1000; c++) begin
      check("rnd_grant", 32'(grant), 32'(m_grant));
      check("rnd_rom_cyc", 32'(rom_cyc), 32'(m_busy));
      check("rnd_rom_addr", 32'(rom_addr), 32'(m_addr));
      exp_ack = rom_ack ? (m_grant & req_cyc) : '0;
      check("rnd_ack", 32'(req_ack), 32'(exp_ack));
      if (exp_ack != '0) check("rnd_rdata", req_rdata, 32'hA500_0000 + 32'(m_addr));
      for (int i = 0; i < N; i++) begin
        if (req_cyc[i]) begin
          if (exp_ack[i]) drop_req(i);
          else if (m_grant[i] && $urandom_range(0, 15) == 0) drop_req(i);
        end else if ($urandom_range(0, 3) == 0) begin
          set_req(i, AW'($urandom_range(0, 255)));
        end
      end
      if (!m_busy) begin
        if (req_cyc != '0) begin
          m_grant = model_pick(req_cyc, m_ptr);
          m_busy  = 1'b1;
          for (int i = 0; i < N; i++) begin
            if (m_grant[i]) begin
              m_addr = req_addr[i*AW +: AW];
              m_ptr  = (i + 1) % N;
            end
          end
        end
      end else if (rom_ack) begin
        m_busy  = 1'b0;
        m_grant = '0;
        m_addr  = '0;
      end
      step();
    end

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
